// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the 3x3 convolution frame scheduler.
// Holds the sequencing state enum and the tap-packing helper.
package conv_sched_pkg;

  localparam int NUM_TAPS  = 9;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 16;
  localparam int TAP_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    CAPTURE  = 3'd2,
    START    = 3'd3,
    WAIT_ENG = 3'd4,
    EMIT     = 3'd5,
    DONE     = 3'd6
  } sched_state_t;

  // Tap i lands in bits [8i+7:8i]
  function automatic logic [NUM_TAPS*PIX_W-1:0] pack_taps(input logic [PIX_W-1:0] taps [NUM_TAPS]);
    logic [NUM_TAPS*PIX_W-1:0] packed_v;
    packed_v = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      packed_v[i*PIX_W +: PIX_W] = taps[i];
    end
    return packed_v;
  endfunction

endpackage

// File: rtl/conv2d_win_addr_gen.sv
// Combinational window address generator: maps (orow, ocol, tap) to the
// raster address of that tap inside the IMG_W-wide image memory.
module conv2d_win_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic [7:0]           orow,
  input  logic [7:0]           ocol,
  input  logic [TAP_IDX_W-1:0] tap,
  output logic [ADDR_W-1:0]    addr
);

  logic [1:0] dy_s;
  logic [1:0] dx_s;

  // Split the tap index into row and column offsets and form the address
  always_comb begin
    dy_s = 2'd0;
    dx_s = 2'd0;
    case (tap)
      4'd0:    begin dy_s = 2'd0; dx_s = 2'd0; end
      4'd1:    begin dy_s = 2'd0; dx_s = 2'd1; end
      4'd2:    begin dy_s = 2'd0; dx_s = 2'd2; end
      4'd3:    begin dy_s = 2'd1; dx_s = 2'd0; end
      4'd4:    begin dy_s = 2'd1; dx_s = 2'd1; end
      4'd5:    begin dy_s = 2'd1; dx_s = 2'd2; end
      4'd6:    begin dy_s = 2'd2; dx_s = 2'd0; end
      4'd7:    begin dy_s = 2'd2; dx_s = 2'd1; end
      4'd8:    begin dy_s = 2'd2; dx_s = 2'd2; end
      default: begin dy_s = 2'd0; dx_s = 2'd0; end
    endcase
    addr = (ADDR_W'(orow) + ADDR_W'(dy_s)) * ADDR_W'(IMG_W) + ADDR_W'(ocol) + ADDR_W'(dx_s);
  end

endmodule

// File: rtl/conv2d_frame_scheduler.sv
// Frame scheduler for the serial 3x3 convolution engine: fetches each window,
// starts the engine, streams results. Optional counters: CONV2D_SCHED_PERF_EN.
module conv2d_frame_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_start,
  output logic                      busy,
  output logic                      frame_done,
  input  logic                      k_wr_en,
  input  logic [TAP_IDX_W-1:0]      k_wr_idx,
  input  logic [PIX_W-1:0]          k_wr_data,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [PIX_W-1:0]          mem_rd_data,
  output logic                      eng_start,
  output logic [NUM_TAPS*PIX_W-1:0] eng_window,
  output logic [NUM_TAPS*PIX_W-1:0] eng_kernel,
  input  logic [RES_W-1:0]          eng_result,
  input  logic                      eng_done,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RES_W-1:0]          res_data,
  output logic                      res_last
`ifdef CONV2D_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_stall
`endif
);

  localparam logic [7:0]           OUT_W_LAST = 8'(IMG_W - 3);
  localparam logic [7:0]           OUT_H_LAST = 8'(IMG_H - 3);
  localparam logic [TAP_IDX_W-1:0] TAP_LAST   = TAP_IDX_W'(NUM_TAPS - 1);

  sched_state_t         state_r, state_s;
  logic [TAP_IDX_W-1:0] tap_r, tap_s;
  logic [7:0]           orow_r, orow_s;
  logic [7:0]           ocol_r, ocol_s;
  logic [ADDR_W-1:0]    addr_s;
  logic                 last_pos_s;
  logic [PIX_W-1:0]     window_r [NUM_TAPS];
  logic [PIX_W-1:0]     kernel_r [NUM_TAPS];

  assign last_pos_s = (orow_r == OUT_H_LAST) && (ocol_r == OUT_W_LAST);
  assign eng_window = pack_taps(window_r);
  assign eng_kernel = pack_taps(kernel_r);

  // Address is computed from the next position so the read strobe can be registered
  conv2d_win_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr_gen (
    .orow (orow_s),
    .ocol (ocol_s),
    .tap  (tap_s),
    .addr (addr_s)
  );

  // Next-state, tap and raster-position logic
  always_comb begin
    state_s = state_r;
    tap_s   = tap_r;
    orow_s  = orow_r;
    ocol_s  = ocol_r;
    case (state_r)
      IDLE: begin
        if (cmd_start) begin
          state_s = FETCH;
          tap_s   = '0;
          orow_s  = 8'd0;
          ocol_s  = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (tap_r == TAP_LAST) begin
          state_s = CAPTURE;
        end else begin
          tap_s = tap_r + 4'd1;
        end
      end
      CAPTURE: state_s = START;
      START:   state_s = WAIT_ENG;
      WAIT_ENG: begin
        if (eng_done) begin
          state_s = EMIT;
        end else begin
          state_s = WAIT_ENG;
        end
      end
      EMIT: begin
        if (res_ready) begin
          tap_s = '0;
          if (ocol_r == OUT_W_LAST) begin
            ocol_s = 8'd0;
            orow_s = orow_r + 8'd1;
          end else begin
            ocol_s = ocol_r + 8'd1;
          end
          if (last_pos_s) begin
            state_s = DONE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = EMIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, position and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      tap_r       <= '0;
      orow_r      <= 8'd0;
      ocol_r      <= 8'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      eng_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
    end else begin
      state_r    <= state_s;
      tap_r      <= tap_s;
      orow_r     <= orow_s;
      ocol_r     <= ocol_s;
      busy       <= state_s inside {FETCH, CAPTURE, START, WAIT_ENG, EMIT};
      frame_done <= (state_s == DONE);
      mem_rd_en  <= (state_s == FETCH);
      eng_start  <= (state_s == START);
      res_valid  <= (state_s == EMIT);
      if (state_s == FETCH) begin
        mem_rd_addr <= addr_s;
      end
      if ((state_r == WAIT_ENG) && eng_done) begin
        res_data <= eng_result;
        res_last <= last_pos_s;
      end
    end
  end

  // Read data trails the strobe by one cycle, so tap i-1 lands while tap i is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) window_r[i] <= '0;
    end else if ((state_r == FETCH) && (tap_r != 4'd0)) begin
      window_r[tap_r - 4'd1] <= mem_rd_data;
    end else if (state_r == CAPTURE) begin
      window_r[NUM_TAPS-1] <= mem_rd_data;
    end
  end

  // Kernel register file, writable only between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) kernel_r[i] <= '0;
    end else if (k_wr_en && (state_r == IDLE) && (k_wr_idx < TAP_IDX_W'(NUM_TAPS))) begin
      kernel_r[k_wr_idx] <= k_wr_data;
    end
  end

`ifdef CONV2D_SCHED_PERF_EN
  // Saturating busy-cycle and output-stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else if ((state_r == IDLE) && cmd_start) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      if (busy && (perf_cycles != 32'hFFFF_FFFF)) perf_cycles <= perf_cycles + 32'd1;
      if ((state_r == EMIT) && !res_ready && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
